operand_fetch: RTL and testbench



---
 rtl/operand_fetch_if.sv | 12 +
 rtl/operand_fetch.sv | 69 ++++++
 tb/tb_operand_fetch.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: key input, ROM port and operand outputs of the operand fetch sequencer
interface operand_fetch_if #(parameter int ADDR_W = 4);
  logic step_n;
  logic [ADDR_W:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] OpA;
  logic [7:0] OpB;
  logic operand_valid;
  logic [ADDR_W-1:0] pair_index;
  modport master(input step_n, rom_data, output rom_addr, OpA, OpB, operand_valid, pair_index);
  modport slave(output step_n, rom_data, input rom_addr, OpA, OpB, operand_valid, pair_index);
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: walks an operand ROM one even/odd pair per debounced key press
module operand_fetch #(
  parameter int ADDR_W = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic clk,
  input logic reset_n,
  operand_fetch_if.master bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {ADDR_A, LATCH_A, LATCH_B, HOLD} state_t;
  state_t state;
  logic [1:0] sync;
  logic key_s, key_d, press_evt, pending, valid, mismatch, settled;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] idx;
  logic [7:0] op_a, op_b;
  assign mismatch = sync[1] != key_s;
  assign settled = mismatch && cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk)
    if (!reset_n) begin
      sync <= 2'b11;
      key_s <= 1'b1;
      key_d <= 1'b1;
      cnt <= '0;
      press_evt <= 1'b0;
    end else begin
      sync <= {sync[0], bus.step_n};
      cnt <= (mismatch && !settled) ? cnt + 1'b1 : '0;
      if (settled) key_s <= sync[1];
      key_d <= key_s;
      press_evt <= key_d & ~key_s;
    end
  // a press arriving mid-fetch is remembered once and replayed from HOLD
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= ADDR_A;
      idx <= '0;
      op_a <= '0;
      op_b <= '0;
      valid <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (press_evt && state != HOLD) pending <= 1'b1;
      case (state)
        ADDR_A: state <= LATCH_A;
        LATCH_A: begin
          op_a <= bus.rom_data;
          state <= LATCH_B;
        end
        LATCH_B: begin
          op_b <= bus.rom_data;
          valid <= 1'b1;
          state <= HOLD;
        end
        HOLD: if (press_evt || pending) begin
          idx <= idx + 1'b1;
          valid <= 1'b0;
          pending <= 1'b0;
          state <= ADDR_A;
        end
      endcase
    end
  assign bus.rom_addr = !reset_n ? '0 : {idx, state != ADDR_A};
  assign bus.OpA = op_a;
  assign bus.OpB = op_b;
  assign bus.operand_valid = valid;
  assign bus.pair_index = idx;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: random key stimulus against a behavioural debounce/fetch model
module tb_operand_fetch;
  localparam int AW = 2;
  localparam int D = 4;
  logic clk = 0;
  logic reset_n = 0;
  always #5 clk = ~clk;
  operand_fetch_if #(.ADDR_W(AW)) bus();
  operand_fetch #(.ADDR_W(AW), .DEBOUNCE_CYCLES(D)) dut(.clk(clk), .reset_n(reset_n), .bus(bus));
  logic [7:0] mem [8] = '{8'h12, 8'h34, 8'hA5, 8'h0F, 8'hFF, 8'h01, 8'h80, 8'h80};
  always_ff @(posedge clk) bus.rom_data <= mem[bus.rom_addr];
  int checks = 0, errors = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
    end
  endtask
  // behavioural model: window debounce, fetch as a 3-cycle countdown after each advance
  bit sh0 = 1, sh1 = 1, mk = 1, mkd = 1, mp = 0, inj = 0;
  bit hist[$];
  int m_idx = 0, m_left = 3;
  bit m_pend = 0, m_valid = 0;
  logic [7:0] m_a = 0, m_b = 0;
  always @(posedge clk) begin
    bit prs, flip;
    if (!reset_n) begin
      sh0 = 1; sh1 = 1; mk = 1; mkd = 1; mp = 0; hist.delete();
      m_idx = 0; m_left = 3; m_pend = 0; m_valid = 0; m_a = 0; m_b = 0;
    end else begin
      prs = mp | inj;
      if (m_left == 0) begin
        if (prs || m_pend) begin
          m_idx = (m_idx + 1) % (1 << AW); m_valid = 0; m_pend = 0; m_left = 3;
        end
      end else begin
        if (prs) m_pend = 1;
        if (m_left == 2) m_a = mem[2 * m_idx];
        if (m_left == 1) begin m_b = mem[2 * m_idx + 1]; m_valid = 1; end
        m_left--;
      end
      mp = mkd & ~mk;
      mkd = mk;
      hist.push_back(sh1);
      if (hist.size() > D) void'(hist.pop_front());
      flip = hist.size() == D;
      foreach (hist[i]) if (hist[i] == mk) flip = 0;
      if (flip) mk = ~mk;
      sh1 = sh0;
      sh0 = bus.step_n;
    end
  end
  bit cmp_on = 0;
  int adv = 0, vlow = 0;
  logic [AW-1:0] pprev;
  always @(negedge clk) begin
    if (bus.pair_index !== pprev) adv++;
    pprev = bus.pair_index;
    if (!bus.operand_valid) vlow++;
    if (cmp_on) begin
      chk("OpA", bus.OpA, m_a);
      chk("OpB", bus.OpB, m_b);
      chk("valid", bus.operand_valid, m_valid);
      chk("pair_index", bus.pair_index, m_idx);
      chk("rom_addr", bus.rom_addr, reset_n ? m_idx * 2 + int'(m_left != 3) : 0);
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic press(input int low);
    bus.step_n = 0;
    cyc(low);
    bus.step_n = 1;
    cyc(16);
  endtask
  task automatic force_seq(input logic [7:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      inj = pat[i];
      if (pat[i]) force dut.press_evt = 1'b1;
      else force dut.press_evt = 1'b0;
      cyc(1);
    end
    inj = 0;
    force dut.press_evt = 1'b0;
    cyc(1);
    release dut.press_evt;
  endtask
  task automatic do_reset(input int n);
    reset_n = 0;
    cyc(n);
    reset_n = 1;
  endtask
  initial begin
    bus.step_n = 1;
    cyc(1);
    cmp_on = 1;
    cyc(2);
    chk("rst_valid", bus.operand_valid, 0);
    chk("rst_OpA", bus.OpA, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    reset_n = 1;
    cyc(2);
    chk("valid_before_3rd_edge", bus.operand_valid, 0);
    cyc(1);
    chk("init_valid", bus.operand_valid, 1);
    chk("init_OpA", bus.OpA, 8'h12);
    chk("init_OpB", bus.OpB, 8'h34);
    chk("init_rom_addr", bus.rom_addr, 1);
    cyc(20);
    chk("hold_OpA", bus.OpA, 8'h12);
    chk("hold_idx", bus.pair_index, 0);
    adv = 0; vlow = 0;
    press(20);
    chk("clean_adv", adv, 1);
    chk("clean_vlow", vlow, 3);
    chk("clean_OpA", bus.OpA, 8'hA5);
    chk("clean_OpB", bus.OpB, 8'h0F);
    chk("clean_idx", bus.pair_index, 1);
    cyc(20);
    chk("release_adv", adv, 1);
    adv = 0;
    for (int i = 0; i < 5; i++) begin
      bus.step_n = i[0];
      cyc(2);
    end
    press(20);
    chk("bounce_adv", adv, 1);
    adv = 0;
    press(3);
    chk("glitch_adv", adv, 0);
    do_reset(2);
    cyc(5);
    adv = 0;
    for (int i = 1; i <= 4; i++) begin
      press(8);
      if (i == 3) begin
        chk("wrap3_OpA", bus.OpA, 8'h80);
        chk("wrap3_OpB", bus.OpB, 8'h80);
      end
    end
    chk("wrap_adv", adv, 4);
    chk("wrap_idx", bus.pair_index, 0);
    chk("wrap_OpA", bus.OpA, 8'h12);
    chk("wrap_OpB", bus.OpB, 8'h34);
    adv = 0;
    force_seq(8'b0101, 4);
    cyc(10);
    chk("pend_adv", adv, 2);
    chk("pend_idx", bus.pair_index, 2);
    adv = 0;
    force_seq(8'b1101, 4);
    cyc(10);
    chk("pend2_adv", adv, 2);
    chk("pend2_idx", bus.pair_index, 0);
    force_seq(8'b1, 1);
    for (int i = 0; i < 10 && m_left != 1; i++) cyc(1);
    chk("latchb_reached", m_left, 1);
    chk("latchb_OpA", bus.OpA, 8'hA5);
    reset_n = 0;
    cyc(1);
    chk("abort_OpA", bus.OpA, 0);
    chk("abort_OpB", bus.OpB, 0);
    chk("abort_valid", bus.operand_valid, 0);
    chk("abort_idx", bus.pair_index, 0);
    reset_n = 1;
    cyc(3);
    chk("refetch_valid", bus.operand_valid, 1);
    chk("refetch_OpA", bus.OpA, 8'h12);
    chk("refetch_OpB", bus.OpB, 8'h34);
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(0, 6)) begin
        bus.step_n = 1'($urandom_range(0, 1));
        cyc($urandom_range(1, 3));
      end
      bus.step_n = 0;
      cyc($urandom_range(1, 12));
      repeat ($urandom_range(0, 4)) begin
        bus.step_n = 1'($urandom_range(0, 1));
        cyc($urandom_range(1, 3));
      end
      bus.step_n = 1;
      cyc($urandom_range(1, 15));
      if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
    end
    cyc(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
